// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle between the IF datapath and fetch_ctrl.
// fetch_ctrl uses the master side; the datapath (or a bench) uses the slave side.
interface fetch_ctrl_if;
  logic        ihit;
  logic        stall;
  logic        halt;
  logic        jump;
  logic        jr;
  logic [31:0] imemaddr;
  logic        ex_branch;
  logic        ex_taken;
  logic        ex_pred;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [2:0]  PCSrc;
  logic        pcen;
  logic        psel;
  logic [31:0] pPC;
  logic        pred_taken;
  logic        flush;

  modport master (
    input  ihit, stall, halt, jump, jr, imemaddr,
    input  ex_branch, ex_taken, ex_pred, ex_pc, ex_target,
    output PCSrc, pcen, psel, pPC, pred_taken, flush
  );

  modport slave (
    output ihit, stall, halt, jump, jr, imemaddr,
    output ex_branch, ex_taken, ex_pred, ex_pc, ex_target,
    input  PCSrc, pcen, psel, pPC, pred_taken, flush
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC-select / fetch controller with redirect pending and halt handling.
// Define BRANCH_PREDICT_EN to add a 16-entry direct-mapped branch predictor.
module fetch_ctrl (
  input  logic          CLK,
  input  logic          RST,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

  localparam logic [2:0] SRC_NPC = 3'd0;
  localparam logic [2:0] SRC_JPC = 3'd1;
  localparam logic [2:0] SRC_JR  = 3'd2;
  localparam logic [2:0] SRC_BR  = 3'd3;
  localparam logic [2:0] SRC_PPC = 3'd4;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_pend_src, w_pend_src_nxt;
  logic [31:0] r_pend_addr, w_pend_addr_nxt;

  logic        w_mispred;
  logic [31:0] w_recov;
  logic [31:0] w_mp_addr;
  logic        w_pred;
  logic [31:0] w_pred_tgt;
  logic        w_unused;

  assign w_mispred = bus.ex_branch & (bus.ex_taken != bus.ex_pred);
  assign w_recov   = bus.ex_pc + 32'd4;
  assign w_mp_addr = bus.ex_taken ? bus.ex_target : w_recov;

`ifdef BRANCH_PREDICT_EN
  logic        r_valid [16];
  logic [25:0] r_tag   [16];
  logic [31:0] r_tgt   [16];
  logic [1:0]  r_cnt   [16];
  logic [3:0]  w_lk_idx, w_up_idx;
  logic        w_up_hit;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign w_lk_idx   = bus.imemaddr[5:2];
  assign w_pred     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == bus.imemaddr[31:6])
                      && r_cnt[w_lk_idx][1];
  assign w_pred_tgt = r_tgt[w_lk_idx];
  assign w_up_idx   = bus.ex_pc[5:2];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == bus.ex_pc[31:6]);
  assign w_unused   = ^bus.imemaddr[1:0];

  // Table update lands on the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
      end
    end else if (bus.ex_branch) begin
      if (w_up_hit) begin
        r_cnt[w_up_idx] <= bus.ex_taken ? sat_inc(r_cnt[w_up_idx]) : sat_dec(r_cnt[w_up_idx]);
        if (bus.ex_taken) r_tgt[w_up_idx] <= bus.ex_target;
      end else if (bus.ex_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= bus.ex_pc[31:6];
        r_tgt[w_up_idx]   <= bus.ex_target;
        r_cnt[w_up_idx]   <= 2'b10;
      end
    end
  end
`else
  assign w_pred     = 1'b0;
  assign w_pred_tgt = 32'd0;
  assign w_unused   = ^bus.imemaddr;
`endif

  assign bus.pred_taken = ~RST & w_pred;

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_src_nxt  = r_pend_src;
    w_pend_addr_nxt = r_pend_addr;
    bus.PCSrc       = SRC_NPC;
    bus.pcen        = 1'b0;
    bus.psel        = 1'b0;
    bus.pPC         = 32'd0;
    bus.flush       = 1'b0;
    if (!RST) begin
      case (r_state)
        RUN, PEND: begin
          if (w_mispred) begin
            bus.flush = 1'b1;
            if (bus.ex_taken) begin
              bus.PCSrc = SRC_BR;
            end else begin
              bus.PCSrc = SRC_PPC;
              bus.pPC   = w_recov;
            end
            if (bus.ihit) begin
              bus.pcen    = 1'b1;
              w_state_nxt = RUN;
              w_pend_src_nxt = SRC_NPC;
            end else begin
              // braddr will be stale by the time we replay, so replay through pPC.
              w_pend_src_nxt  = SRC_PPC;
              w_pend_addr_nxt = w_mp_addr;
              w_state_nxt     = PEND;
            end
          end else if (bus.halt) begin
            w_state_nxt = HALTED;
          end else if (r_state == PEND) begin
            if (bus.ihit && (!bus.stall || r_pend_src == SRC_PPC)) begin
              bus.PCSrc      = r_pend_src;
              bus.pPC        = r_pend_addr;
              bus.pcen       = 1'b1;
              w_state_nxt    = RUN;
              w_pend_src_nxt = SRC_NPC;
            end
          end else if (bus.jr || bus.jump) begin
            bus.PCSrc = bus.jr ? SRC_JR : SRC_JPC;
            if (bus.ihit) begin
              bus.pcen = ~bus.stall;
            end else begin
              w_pend_src_nxt  = bus.jr ? SRC_JR : SRC_JPC;
              w_pend_addr_nxt = 32'd0;
              w_state_nxt     = PEND;
            end
          end else begin
            bus.pcen = bus.ihit & ~bus.stall;
            if (w_pred) begin
              bus.PCSrc = SRC_PPC;
              bus.psel  = 1'b1;
              bus.pPC   = w_pred_tgt;
            end
          end
        end
        HALTED: ;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= RUN;
      r_pend_src <= SRC_NPC;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_src <= w_pend_src_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    r_pend_addr <= w_pend_addr_nxt;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl, one vector per clock cycle.
module tb_fetch_ctrl;

`ifdef BRANCH_PREDICT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();
  fetch_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    bit        r, ih, st, hl, jp, jrr;
    bit [31:0] ia;
    bit        eb, et, ep;
    bit [31:0] epc, etg;
    bit [2:0]  src;
    bit        pe, ps;
    bit [31:0] pp;
    bit        pt, fl;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(bit r, bit ih, bit st, bit hl, bit jp, bit jrr, bit [31:0] ia,
                              bit eb, bit et, bit ep, bit [31:0] epc, bit [31:0] etg,
                              bit [2:0] src, bit pe, bit ps, bit [31:0] pp, bit pt, bit fl);
    vec_t v;
    v.r = r; v.ih = ih; v.st = st; v.hl = hl; v.jp = jp; v.jrr = jrr; v.ia = ia;
    v.eb = eb; v.et = et; v.ep = ep; v.epc = epc; v.etg = etg;
    v.src = src; v.pe = pe; v.ps = ps; v.pp = pp; v.pt = pt; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string tag, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", tag, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    @(posedge clk);
    #1;
    rst = v.r;
    bus.ihit = v.ih; bus.stall = v.st; bus.halt = v.hl; bus.jump = v.jp; bus.jr = v.jrr;
    bus.imemaddr = v.ia; bus.ex_branch = v.eb; bus.ex_taken = v.et; bus.ex_pred = v.ep;
    bus.ex_pc = v.epc; bus.ex_target = v.etg;
    #3;
    chk("PCSrc", row, {29'd0, bus.PCSrc}, {29'd0, v.src});
    chk("pcen", row, {31'd0, bus.pcen}, {31'd0, v.pe});
    chk("psel", row, {31'd0, bus.psel}, {31'd0, v.ps});
    chk("pPC", row, bus.pPC, v.pp);
    chk("pred_taken", row, {31'd0, bus.pred_taken}, {31'd0, v.pt});
    chk("flush", row, {31'd0, bus.flush}, {31'd0, v.fl});
  endtask

  initial begin
    rst = 1'b1;
    bus.ihit = 0; bus.stall = 0; bus.halt = 0; bus.jump = 0; bus.jr = 0;
    bus.imemaddr = 0; bus.ex_branch = 0; bus.ex_taken = 0; bus.ex_pred = 0;
    bus.ex_pc = 0; bus.ex_target = 0;

    //              r ih st hl jp jr ia            eb et ep epc           etg        src pe ps pp            pt  fl
    tbl.push_back(mk(1,1,0,0,0,0, 32'h0,        0,0,0, 32'h0,        32'h0,     0,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h0,        0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h4,        0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h8,        0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h40,       0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    // first taken resolution of 0x40; lookup of 0x40 in the same cycle still misses
    tbl.push_back(mk(0,1,0,0,0,0, 32'h40,       1,1,0, 32'h40,       32'h100,   3,1,0, 32'h0,        0,  1));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h40,       0,0,0, 32'h0,        32'h0,     EN?3'd4:3'd0,1,EN, EN?32'h100:32'h0, EN, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h100,      1,1,EN,32'h40,       32'h100,   EN?3'd0:3'd3,1,0, 32'h0,    0,  !EN));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h40,       0,0,0, 32'h0,        32'h0,     EN?3'd4:3'd0,1,EN, EN?32'h100:32'h0, EN, 0));
    // not-taken mispredict -> recovery through pPC, flush one cycle
    tbl.push_back(mk(0,1,0,0,0,0, 32'h44,       1,0,1, 32'h40,       32'h100,   4,1,0, 32'h44,       0,  1));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h44,       0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,1,0,0,0, 32'h48,       0,0,0, 32'h0,        32'h0,     0,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,1,0,0,0, 32'h48,       1,1,0, 32'h200,      32'h300,   3,1,0, 32'h0,        0,  1));
    // jump while ihit=0: two dead cycles, applied on ihit
    tbl.push_back(mk(0,0,0,0,1,0, 32'h4C,       0,0,0, 32'h0,        32'h0,     1,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,0,0,0,1,0, 32'h4C,       0,0,0, 32'h0,        32'h0,     0,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h4C,       0,0,0, 32'h0,        32'h0,     1,1,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h50,       0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    // pending jr replaced by a newer mispredict
    tbl.push_back(mk(0,0,0,0,0,1, 32'h54,       0,0,0, 32'h0,        32'h0,     2,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h54,       1,0,1, 32'h80,       32'h0,     4,0,0, 32'h84,       0,  1));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h54,       0,0,0, 32'h0,        32'h0,     4,1,0, 32'h84,       0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h84,       0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    // mispredict + jr + halt together, then halt held
    tbl.push_back(mk(0,1,0,1,0,1, 32'h88,       1,1,0, 32'h60,       32'h400,   3,1,0, 32'h0,        0,  1));
    tbl.push_back(mk(0,1,0,1,0,0, 32'h400,      0,0,0, 32'h0,        32'h0,     0,0,0, 32'h0,        0,  0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,0,0,0, 32'h8,      1,1,0, 32'h10,       32'h20,    0,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h60,       0,0,0, 32'h0,        32'h0,     0,0,0, 32'h0,        0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h60,       0,0,0, 32'h0,        32'h0,     0,1,0, 32'h0,        0,  0));
    // recovery address wrap
    tbl.push_back(mk(0,1,0,0,0,0, 32'h64,       1,0,1, 32'hFFFFFFF8, 32'h0,     4,1,0, 32'hFFFFFFFC, 0,  1));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h68,       1,0,1, 32'hFFFFFFFC, 32'h0,     4,1,0, 32'h0,        0,  1));

    foreach (tbl[i]) apply(tbl[i], i);

    // latched mispredict overrides stall when replayed from PEND
    apply(mk(0,0,0,0,0,0, 32'h6C, 1,0,1, 32'h20, 32'h0, 4,0,0, 32'h24, 0,1), 100);
    apply(mk(0,1,1,0,0,0, 32'h6C, 0,0,0, 32'h0,  32'h0, 4,1,0, 32'h24, 0,0), 101);
    apply(mk(0,1,0,0,0,0, 32'h24, 0,0,0, 32'h0,  32'h0, 0,1,0, 32'h0,  0,0), 102);

    // reset in the middle of PEND discards the latched jump
    apply(mk(0,0,0,0,1,0, 32'h28, 0,0,0, 32'h0,  32'h0, 1,0,0, 32'h0,  0,0), 200);
    apply(mk(1,0,0,0,0,0, 32'h28, 0,0,0, 32'h0,  32'h0, 0,0,0, 32'h0,  0,0), 201);
    apply(mk(0,1,0,0,0,0, 32'h0,  0,0,0, 32'h0,  32'h0, 0,1,0, 32'h0,  0,0), 202);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
